// File: rtl/sg4_pixel_shifter_if.sv
// Pixel-shifter bus: character upload, scan timing strobes and registered dot outputs.
// The master drives the character and timing inputs; the slave is the shifter.
interface sg4_pixel_shifter_if;
  logic       pixelEn;
  logic       lineStart;
  logic       frameStart;
  logic       charValid;
  logic [7:0] charData;
  logic       charReady;
  logic [3:0] row;
  logic       pixelOut;
  logic [3:0] colourOut;
  logic       pixelValid;
  logic       underrun;

  modport master (
    output pixelEn, lineStart, frameStart, charValid, charData,
    input  charReady, row, pixelOut, colourOut, pixelValid, underrun
  );

  modport slave (
    input  pixelEn, lineStart, frameStart, charValid, charData,
    output charReady, row, pixelOut, colourOut, pixelValid, underrun
  );
endinterface

// File: rtl/sg4_pixel_shifter.sv
// Semigraphics-4 dot shifter: expands one quadrant byte into 8 dots per scanline row.
// Define SG4_PIXEL_DOUBLE_EN to emit every dot on two consecutive pixelEn strobes.
module sg4_pixel_shifter (
  input  logic                  clk,
  input  logic                  reset,
  sg4_pixel_shifter_if.slave    bus
);

`ifdef SG4_PIXEL_DOUBLE_EN
  localparam logic [4:0] charStrobes = 5'd16;
`else
  localparam logic [4:0] charStrobes = 5'd8;
`endif

  logic [3:0] rowReg;
  logic [4:0] count;
  logic [7:0] shift;
  logic [3:0] charColour;
  logic       pixelOutReg;
  logic [3:0] colourOutReg;
  logic       pixelValidReg;
  logic       underrunReg;

  logic [3:0] rowNext;
  logic [4:0] countNext;
  logic [7:0] shiftNext;
  logic [3:0] charColourNext;
  logic       pixelOutNext;
  logic [3:0] colourOutNext;
  logic       pixelValidNext;
  logic       underrunNext;

  logic       charReadyInt;
  logic       transfer;
  logic [1:0] quadField;
  logic [7:0] quadPattern;
  logic       advanceBit;

  // Ready when empty, or when the final strobe of the current character is being consumed.
  always_comb begin
    charReadyInt = ((count == 5'd0) || ((count == 5'd1) && bus.pixelEn))
                   && !bus.lineStart && !bus.frameStart && !reset;
    transfer     = bus.charValid && charReadyInt;
  end

  // Top half of the cell shows the low quadrant pair, bottom half the high pair.
  always_comb begin
    quadField   = (rowReg < 4'd6) ? bus.charData[1:0] : bus.charData[3:2];
    quadPattern = 8'h00;
    case (quadField)
      2'b00:   quadPattern = 8'hFF;
      2'b01:   quadPattern = 8'hF0;
      2'b10:   quadPattern = 8'h0F;
      default: quadPattern = 8'h00;
    endcase
  end

`ifdef SG4_PIXEL_DOUBLE_EN
  // Odd counts are the second copy of a dot, so the pattern moves on only then.
  always_comb advanceBit = count[0];
`else
  always_comb advanceBit = 1'b1;
`endif

  always_comb begin
    rowNext        = rowReg;
    countNext      = count;
    shiftNext      = shift;
    charColourNext = charColour;
    pixelOutNext   = pixelOutReg;
    colourOutNext  = colourOutReg;
    pixelValidNext = pixelValidReg;
    underrunNext   = 1'b0;

    if (bus.pixelEn) begin
      if (count != 5'd0) begin
        pixelOutNext   = shift[7];
        colourOutNext  = charColour;
        pixelValidNext = 1'b1;
      end else begin
        pixelOutNext   = 1'b0;
        colourOutNext  = 4'd0;
        pixelValidNext = 1'b0;
        underrunNext   = 1'b1;
      end
    end

    // A flush outranks everything; a load replaces whatever the last strobe left behind.
    if (bus.frameStart || bus.lineStart) begin
      countNext = 5'd0;
    end else if (transfer) begin
      shiftNext      = quadPattern;
      countNext      = charStrobes;
      charColourNext = {1'b0, bus.charData[6:4]} + 4'd1;
    end else if (bus.pixelEn && (count != 5'd0)) begin
      countNext = count - 5'd1;
      if (advanceBit) begin
        shiftNext = {shift[6:0], 1'b0};
      end
    end

    if (bus.frameStart) begin
      rowNext = 4'd0;
    end else if (bus.lineStart) begin
      rowNext = (rowReg == 4'd11) ? 4'd0 : rowReg + 4'd1;
    end
  end

  // Single register bank; synchronous reset overrides every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      rowReg        <= 4'd0;
      count         <= 5'd0;
      shift         <= 8'd0;
      charColour    <= 4'd0;
      pixelOutReg   <= 1'b0;
      colourOutReg  <= 4'd0;
      pixelValidReg <= 1'b0;
      underrunReg   <= 1'b0;
    end else begin
      rowReg        <= rowNext;
      count         <= countNext;
      shift         <= shiftNext;
      charColour    <= charColourNext;
      pixelOutReg   <= pixelOutNext;
      colourOutReg  <= colourOutNext;
      pixelValidReg <= pixelValidNext;
      underrunReg   <= underrunNext;
    end
  end

  assign bus.charReady  = charReadyInt;
  assign bus.row        = rowReg;
  assign bus.pixelOut   = pixelOutReg;
  assign bus.colourOut  = colourOutReg;
  assign bus.pixelValid = pixelValidReg;
  assign bus.underrun   = underrunReg;

endmodule

// File: tb/tb_sg4_pixel_shifter.sv
// Directed bench for sg4_pixel_shifter; expected dot streams are written out by hand.
// Dot expectations stretch automatically when SG4_PIXEL_DOUBLE_EN is defined.
module tb_sg4_pixel_shifter;

`ifdef SG4_PIXEL_DOUBLE_EN
  localparam int REP = 2;
`else
  localparam int REP = 1;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  sg4_pixel_shifter_if bus ();

  sg4_pixel_shifter dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic pe, input logic ls, input logic fs,
                               input logic cv, input logic [7:0] cd);
    bus.pixelEn    = pe;
    bus.lineStart  = ls;
    bus.frameStart = fs;
    bus.charValid  = cv;
    bus.charData   = cd;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic runDots(input string tag, input logic [7:0] pat, input logic [3:0] col);
    for (int i = 0; i < 8 * REP; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      tick;
      checkOutput({tag, "_pix"}, bus.pixelOut, pat[7 - i / REP]);
      checkOutput({tag, "_col"}, bus.colourOut, col);
      checkOutput({tag, "_val"}, bus.pixelValid, 1'b1);
      checkOutput({tag, "_urn"}, bus.underrun, 1'b0);
    end
  endtask

  task automatic expectUnderrun(input string tag);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    tick;
    checkOutput({tag, "_pix"}, bus.pixelOut, 1'b0);
    checkOutput({tag, "_col"}, bus.colourOut, 4'd0);
    checkOutput({tag, "_val"}, bus.pixelValid, 1'b0);
    checkOutput({tag, "_urn"}, bus.underrun, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick;
    checkOutput({tag, "_urnclr"}, bus.underrun, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL timeout observed=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    // Reset with strobes active: nothing may move and charReady stays low.
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h25);
    checkOutput("rst_ready", bus.charReady, 1'b0);
    tick;
    tick;
    checkOutput("rst_row", bus.row, 4'd0);
    checkOutput("rst_pix", bus.pixelOut, 1'b0);
    checkOutput("rst_col", bus.colourOut, 4'd0);
    checkOutput("rst_val", bus.pixelValid, 1'b0);
    checkOutput("rst_urn", bus.underrun, 1'b0);

    reset = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h25);
    checkOutput("fs_ready", bus.charReady, 1'b0);
    tick;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h25);
    checkOutput("c25_ready", bus.charReady, 1'b1);
    tick;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick;
    checkOutput("c25_idle_val", bus.pixelValid, 1'b0);
    runDots("c25", 8'hF0, 4'd3);
    expectUnderrun("u25");

    for (int i = 0; i < 7; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      tick;
    end
    checkOutput("row7", bus.row, 4'd7);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h78);
    tick;
    runDots("c78", 8'h0F, 4'd8);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    tick;
    checkOutput("hold_pix", bus.pixelOut, 1'b1);
    checkOutput("hold_col", bus.colourOut, 4'd8);
    checkOutput("hold_val", bus.pixelValid, 1'b1);
    expectUnderrun("u78");

    // Back-to-back characters with charValid held high through the handover.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
    tick;
    checkOutput("fs_row", bus.row, 4'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    tick;
    for (int i = 0; i < 8 * REP; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h13);
      checkOutput("b2b_ready", bus.charReady, (i == 8 * REP - 1) ? 1'b1 : 1'b0);
      tick;
      checkOutput("b2b_pix", bus.pixelOut, 1'b1);
      checkOutput("b2b_col", bus.colourOut, 4'd1);
      checkOutput("b2b_val", bus.pixelValid, 1'b1);
      checkOutput("b2b_urn", bus.underrun, 1'b0);
    end
    runDots("c13", 8'h00, 4'd2);
    expectUnderrun("u13");

    // lineStart partway through a character flushes it.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h25);
    tick;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      tick;
      checkOutput("part_pix", bus.pixelOut, 1'b1);
    end
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    checkOutput("ls_ready", bus.charReady, 1'b0);
    tick;
    checkOutput("ls_row", bus.row, 4'd1);
    expectUnderrun("uflush");

    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
      tick;
    end
    checkOutput("row11", bus.row, 4'd11);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    tick;
    checkOutput("row_wrap", bus.row, 4'd0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    tick;
    checkOutput("row1", bus.row, 4'd1);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
    tick;
    checkOutput("fs_wins", bus.row, 4'd0);

    // Reset in the middle of a character drops the remaining dots.
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    tick;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h25);
    tick;
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
      tick;
      checkOutput("mid_pix", bus.pixelOut, 1'b1);
    end
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    tick;
    checkOutput("midrst_row", bus.row, 4'd0);
    checkOutput("midrst_pix", bus.pixelOut, 1'b0);
    checkOutput("midrst_val", bus.pixelValid, 1'b0);
    checkOutput("midrst_urn", bus.underrun, 1'b0);
    reset = 1'b0;
    expectUnderrun("urst");

    // Load on an empty strobe: that edge still reports an underrun dot.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 8'h25);
    checkOutput("emptyload_ready", bus.charReady, 1'b1);
    tick;
    checkOutput("emptyload_urn", bus.underrun, 1'b1);
    checkOutput("emptyload_val", bus.pixelValid, 1'b0);
    runDots("c25b", 8'hF0, 4'd3);
    expectUnderrun("u25b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sg4_pixel_shifter.md
SG4_PIXEL_SHIFTER -- requirements
Module: sg4_pixel_shifter

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, which are its first two ports as listed below.
REQ-002 clk  in  1  system clock; all state changes on the rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 pixelEn  in  1  dot-clock enable; one strobe per displayed dot.
REQ-005 lineStart  in  1  one-cycle pulse at the start of each scanline.
REQ-006 frameStart  in  1  one-cycle pulse at the start of each frame.
REQ-007 charValid  in  1  upstream has a semigraphics-4 character byte on charData.
REQ-008 charData  in  8  character byte: [3:0] quadrant bits, [6:4] colour code, [7] ignored.
REQ-009 charReady  out  1  the shifter accepts charData this cycle.
REQ-010 row  out  4  current character row, 0..11.
REQ-011 pixelOut  out  1  registered dot value, 1 = foreground.
REQ-012 colourOut  out  4  registered colour of the current dot.
REQ-013 pixelValid  out  1  registered; 1 = the current dot comes from a loaded character.
REQ-014 underrun  out  1  one-cycle pulse when a pixelEn strobe finds the shifter empty.

Function
REQ-015 A transfer SHALL occur on a rising edge where charValid and charReady are both 1; no transfer SHALL occur otherwise.
REQ-016 charReady SHALL equal (count==0 OR (count==1 AND pixelEn)) AND NOT lineStart AND NOT frameStart AND NOT reset.
- count is the number of dots remaining in the shifter.
REQ-017 On a transfer, the shifter SHALL load the 8-bit pattern selected by the 2-bit field charData[1:0] when row<6, or by charData[3:2] when row>=6; the field values map to patterns as follows: 00 -> FF, 01 -> F0, 10 -> 0F, 11 -> 00.
REQ-018 On a transfer, the character colour SHALL be latched as ({1'b0,charData[6:4]} + 1), giving 1..8 with no wrap.
REQ-019 On a pixelEn edge with count>0, the block SHALL register: pixelOut = shift[7], colourOut = latched colour, pixelValid = 1; it SHALL then shift left by one and decrement count.
REQ-020 On a pixelEn edge with count==0, the block SHALL register pixelOut=0, colourOut=0, pixelValid=0 and pulse underrun for one cycle.
REQ-021 A transfer on the same edge as the last dot (count==1, pixelEn) SHALL be seamless: the next pixelEn emits bit 7 of the new pattern.
REQ-022 A transfer with count==0 on a pixelEn edge SHALL load the new pattern; that edge SHALL still register the underrun dot defined in REQ-020.
REQ-023 Outputs SHALL hold their values on cycles without pixelEn.
REQ-024 lineStart SHALL increment row, wrapping from 11 to 0, and flush the shifter (count=0).
REQ-025 frameStart SHALL set row=0 and flush the shifter; when lineStart and frameStart occur together, frameStart SHALL win.
REQ-026 The row value used for pattern selection SHALL be the row value before any row update on the same edge.
REQ-027 Latency: a transferred dot SHALL appear on pixelOut at the first pixelEn edge after the transfer edge (REQ-021).

Reset
REQ-028 Reset SHALL set row=0, count=0, shift=0, latched colour=0, pixelOut=0, colourOut=0, pixelValid=0 and underrun=0.
REQ-029 Reset SHALL override all other inputs, and charReady SHALL be 0 while reset is high.
REQ-030 Reset asserted mid-character SHALL discard the remaining dots; the first pixelEn after release SHALL produce an underrun dot.

Configuration
REQ-031 The macro SG4_PIXEL_DOUBLE_EN SHALL control dot doubling.
- When defined, each pattern bit SHALL be emitted on two consecutive pixelEn strobes (16 strobes per character, count range 0..16).
- When defined, charReady SHALL use count==1 for the last half-dot.
REQ-032 Without SG4_PIXEL_DOUBLE_EN, each bit SHALL be emitted once (8 strobes per character); all other behaviour SHALL be identical.

Verification
REQ-033 Reset, frameStart, charData=0x25 at row 0, then pixelEn every cycle -> colourOut=3 for 8 dots, pixelOut 1,1,1,1,0,0,0,0, pixelValid=1, then underrun pulses.
REQ-034 Seven lineStart pulses, then charData=0x78 -> row=7, field [3:2]=10, colourOut=8, pixelOut 0,0,0,0,1,1,1,1.
REQ-035 charValid held high continuously with 0x00 then 0x13 -> 16 back-to-back dots with no pixelValid gap and no underrun; first 8 dots all 1 with colour 1, next 8 dots all 0 with colour 2.
REQ-036 lineStart pulse after 3 of 8 dots -> remaining dots discarded, next strobe pixelOut=0, pixelValid=0, underrun=1, charReady=0 during the pulse; 12 lineStart pulses -> row wraps 11 to 0; lineStart and frameStart together -> row=0.
REQ-037 With SG4_PIXEL_DOUBLE_EN defined, charData=0x01 at row 0 -> pixelOut 1 for 8 strobes then 0 for 8 strobes, charReady high on the 16th strobe.
